// File: rtl/data_byte_writer_if.sv
// Handshake and byte-write bus of data_byte_writer: the request side from the
// control unit plus the byte-wide memory write port.
interface data_byte_writer_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  Start;
    logic [31:0]           DIn;
    logic [ADDR_WIDTH-1:0] AddrIn;
    logic [1:0]            Size;
    logic                  MemReady;
    logic                  MemWE;
    logic [ADDR_WIDTH-1:0] MemAddr;
    logic [7:0]            MemData;
    logic                  Busy;
    logic                  Done;
    logic                  Error;

    // Writer side
    modport slave (
        input  Start, DIn, AddrIn, Size, MemReady,
        output MemWE, MemAddr, MemData, Busy, Done, Error
    );

    // Control unit / memory side
    modport master (
        output Start, DIn, AddrIn, Size, MemReady,
        input  MemWE, MemAddr, MemData, Busy, Done, Error
    );
endinterface

// File: rtl/data_byte_writer.sv
// Serializes a 32-bit word into 1, 2 or 4 little-endian byte writes starting
// at a base byte address. Every output is a register, so nothing on the bus
// depends combinationally on an input.
module data_byte_writer #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic          Clock,
    input  logic          Reset,
    data_byte_writer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state;
    logic [31:0]           word;
    logic [ADDR_WIDTH-1:0] base;
    logic [1:0]            idx;
    logic [1:0]            last;
    logic [1:0]            idx_nxt;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_data;
    logic                  busy;
    logic                  done;
    logic                  err;

    assign idx_nxt = idx + 2'd1;

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] i);
        return w[{i, 3'b000} +: 8];
    endfunction

    // Size code to index of the final byte; reserved code never reaches WRITE
    function automatic logic [1:0] last_of(input logic [1:0] sz);
        case (sz)
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    // Transfer FSM; bus outputs are registered alongside the state so they
    // always present the byte the memory will take at the next edge.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            word     <= '0;
            base     <= '0;
            idx      <= '0;
            last     <= '0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done   <= 1'b0;
                    busy   <= 1'b0;
                    mem_we <= 1'b0;
                    err    <= bus.Start && (bus.Size == 2'b11);
                    if (bus.Start && (bus.Size != 2'b11)) begin
                        word     <= bus.DIn;
                        base     <= bus.AddrIn;
                        last     <= last_of(bus.Size);
                        idx      <= 2'd0;
                        state    <= WRITE;
                        mem_we   <= 1'b1;
                        mem_addr <= bus.AddrIn;
                        mem_data <= bus.DIn[7:0];
                        busy     <= 1'b1;
                    end
                end
                WRITE: begin
                    err <= 1'b0;
                    // MemReady low leaves everything as is: the byte is re-offered
                    if (bus.MemReady) begin
                        if (idx == last) begin
                            state    <= DONE;
                            mem_we   <= 1'b0;
                            mem_addr <= '0;
                            mem_data <= '0;
                            done     <= 1'b1;
                        end else begin
                            idx      <= idx_nxt;
                            // Address arithmetic wraps naturally at ADDR_WIDTH bits
                            mem_addr <= base + ADDR_WIDTH'(idx_nxt);
                            mem_data <= byte_of(word, idx_nxt);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    idx   <= 2'd0;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    err   <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    mem_we <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                    err    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.MemWE   = mem_we;
    assign bus.MemAddr = mem_addr;
    assign bus.MemData = mem_data;
    assign bus.Busy    = busy;
    assign bus.Done    = done;
    assign bus.Error   = err;
endmodule

// File: tb/tb_data_byte_writer.sv
// Bench for data_byte_writer: directed scenarios plus random transfers checked
// against a byte-list model (byte i of the word goes to base+i, mod 2^16).
module tb_data_byte_writer;
    logic Clock;
    logic Reset;
    int   checks;
    int   failures;

    data_byte_writer_if #(.ADDR_WIDTH(16)) bus ();

    data_byte_writer #(.ADDR_WIDTH(16)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    // One transfer, entered and left at a falling edge. stall_pct < 0 selects
    // the fixed pattern "two not-ready cycles on byte 1"; spam re-asserts Start
    // with random Size throughout the transfer, which must be ignored.
    task automatic run_xfer(input logic [31:0] din, input logic [15:0] addr,
                            input logic [1:0] size, input int stall_pct,
                            input bit spam, input string name);
        int          n;
        int          nacc;
        int          cyc;
        int          stalls;
        bit          got_done;
        bit          ready;
        logic [15:0] ea;
        logic [7:0]  ed;
        n = nbytes(size); nacc = 0; cyc = 0; stalls = 0; got_done = 0;
        bus.Start = 1'b1; bus.DIn = din; bus.AddrIn = addr; bus.Size = size;
        bus.MemReady = 1'b1;
        @(posedge Clock); #1;
        bus.Start = 1'b0; bus.DIn = $urandom; bus.AddrIn = 16'($urandom); bus.Size = 2'($urandom);
        while (!got_done && cyc < 64) begin
            @(negedge Clock);
            cyc++;
            if (bus.Done === 1'b1) begin
                got_done = 1;
                bus.Start = 1'b0;
                checks++;
                if (cyc != n + stalls + 1 || nacc != n || bus.MemWE !== 1'b0 || bus.Busy !== 1'b1) begin
                    failures++;
                    $display("FAIL %s done: cycle=%0d bytes=%0d we=%b busy=%b, want cycle=%0d bytes=%0d we=0 busy=1",
                             name, cyc, nacc, bus.MemWE, bus.Busy, n + stalls + 1, n);
                end
            end else begin
                ea = addr + 16'(nacc);
                ed = 8'(din >> (8 * nacc));
                checks++;
                if (nacc >= n || bus.MemWE !== 1'b1 || bus.MemAddr !== ea || bus.MemData !== ed ||
                    bus.Busy !== 1'b1 || bus.Error !== 1'b0) begin
                    failures++;
                    $display("FAIL %s byte%0d cycle%0d: we=%b addr=%h data=%h busy=%b err=%b, want we=1 addr=%h data=%h busy=1 err=0",
                             name, nacc, cyc, bus.MemWE, bus.MemAddr, bus.MemData, bus.Busy, bus.Error, ea, ed);
                end
                if (stall_pct < 0) ready = !(nacc == 1 && stalls < 2);
                else               ready = ($urandom_range(99) >= stall_pct);
                bus.MemReady = ready;
                if (ready) nacc++;
                else       stalls++;
                if (spam) begin
                    bus.Start = 1'($urandom_range(1));
                    bus.Size  = 2'($urandom);
                end
            end
        end
        bus.Start = 1'b0;
        if (!got_done) begin
            checks++;
            failures++;
            $display("FAIL %s timeout: no Done within %0d cycles, want Done", name, cyc);
        end
        if (stall_pct < 0) begin
            checks++;
            if (cyc - 1 != 6) begin
                failures++;
                $display("FAIL %s stall_len: write cycles=%0d, want 6", name, cyc - 1);
            end
        end
        @(negedge Clock);
        checks++;
        if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.MemWE !== 1'b0 || bus.Error !== 1'b0) begin
            failures++;
            $display("FAIL %s idle_after: busy=%b done=%b we=%b err=%b, want all 0",
                     name, bus.Busy, bus.Done, bus.MemWE, bus.Error);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (bus.MemWE !== 1'b0 || bus.MemAddr !== 16'h0 || bus.MemData !== 8'h0 ||
            bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.Error !== 1'b0) begin
            failures++;
            $display("FAIL %s: we=%b addr=%h data=%h busy=%b done=%b err=%b, want all 0",
                     name, bus.MemWE, bus.MemAddr, bus.MemData, bus.Busy, bus.Done, bus.Error);
        end
    endtask

    task automatic test_reset();
        bus.Start = 1'b0; bus.DIn = '0; bus.AddrIn = '0; bus.Size = '0; bus.MemReady = 1'b1;
        Reset = 1'b0;
        #1 Reset = 1'b1;
        #2 check_all_zero("reset_async");
        @(negedge Clock);
        check_all_zero("reset_held");
        Reset = 1'b0;
        @(negedge Clock);
        check_all_zero("reset_released");
    endtask

    task automatic test_word();
        run_xfer(32'hA1B2C3D4, 16'h0100, 2'b10, 0, 1'b0, "word");
    endtask

    task automatic test_sizes();
        run_xfer(32'h11223344, 16'h0020, 2'b00, 0, 1'b0, "size_byte");
        run_xfer(32'h11223344, 16'h0020, 2'b01, 0, 1'b0, "size_half");
    endtask

    task automatic test_stall();
        run_xfer(32'hCAFEF00D, 16'h1234, 2'b10, -1, 1'b0, "stall");
    endtask

    task automatic test_wrap();
        run_xfer(32'h89ABCDEF, 16'hFFFE, 2'b10, 0, 1'b0, "wrap_fffe");
        run_xfer(32'h01020304, 16'hFFFF, 2'b10, 0, 1'b0, "wrap_ffff");
    endtask

    task automatic test_error();
        bus.Start = 1'b1; bus.Size = 2'b11; bus.DIn = $urandom; bus.AddrIn = 16'h4000;
        @(posedge Clock); #1;
        bus.Start = 1'b0; bus.Size = 2'b00;
        @(negedge Clock);
        checks++;
        if (bus.Error !== 1'b1 || bus.MemWE !== 1'b0 || bus.Busy !== 1'b0) begin
            failures++;
            $display("FAIL error_pulse: err=%b we=%b busy=%b, want err=1 we=0 busy=0",
                     bus.Error, bus.MemWE, bus.Busy);
        end
        @(negedge Clock);
        checks++;
        if (bus.Error !== 1'b0 || bus.MemWE !== 1'b0 || bus.Busy !== 1'b0) begin
            failures++;
            $display("FAIL error_clear: err=%b we=%b busy=%b, want err=0 we=0 busy=0",
                     bus.Error, bus.MemWE, bus.Busy);
        end
    endtask

    task automatic test_start_ignored();
        run_xfer(32'h5A6B7C8D, 16'h0300, 2'b10, 0, 1'b1, "start_ignored_word");
        run_xfer(32'h5A6B7C8D, 16'h0300, 2'b00, 30, 1'b1, "start_ignored_byte");
    endtask

    task automatic test_reset_mid();
        bus.Start = 1'b1; bus.DIn = 32'hDEADBEEF; bus.AddrIn = 16'h0700; bus.Size = 2'b10;
        bus.MemReady = 1'b1;
        @(posedge Clock); #1;
        bus.Start = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        checks++;
        if (bus.MemWE !== 1'b1 || bus.MemAddr !== 16'h0701 || bus.MemData !== 8'hBE) begin
            failures++;
            $display("FAIL reset_mid_byte1: we=%b addr=%h data=%h, want we=1 addr=0701 data=be",
                     bus.MemWE, bus.MemAddr, bus.MemData);
        end
        #2 Reset = 1'b1;
        #1 check_all_zero("reset_mid_async");
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        check_all_zero("reset_mid_idle");
        run_xfer(32'h000000A5, 16'h0042, 2'b00, 0, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        for (int t = 0; t < 24; t++) begin
            run_xfer($urandom, 16'($urandom), 2'($urandom_range(2)), 40, t[0], "random");
        end
    endtask

    task automatic test_back_to_back();
        // run_xfer returns at the first idle cycle, so each call starts at the earliest legal edge
        run_xfer(32'h10203040, 16'h8000, 2'b01, 0, 1'b0, "b2b_0");
        run_xfer(32'h50607080, 16'h8002, 2'b10, 0, 1'b0, "b2b_1");
        run_xfer(32'h90A0B0C0, 16'h8006, 2'b00, 0, 1'b0, "b2b_2");
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_word();
        test_sizes();
        test_stall();
        test_wrap();
        test_error();
        test_start_ignored();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
